// File: rtl/counter_slice_arbiter_pkg.sv
// Shared types and the round-robin search helper for the time-sliced counter arbiter.
// Sized for up to MAX_NREQ requesters so later arbiters can reuse the same helper.
package counter_slice_arbiter_pkg;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_result_t;

    // Rotate so the slot after 'last' sits at bit 0, priority-encode the lowest set bit,
    // then map that rotated position back to a requester index. 'last' itself is scanned
    // last, which gives the current owner the lowest priority.
    function automatic rr_result_t rr_next(
        input logic [MAX_NREQ-1:0] req,
        input logic [IDX_W-1:0]    last,
        input logic [IDX_W:0]      nreq
    );
        logic [MAX_NREQ-1:0] rot;
        logic [IDX_W:0]      pos [MAX_NREQ];
        rr_result_t          res;
        rot = '0;
        res = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            pos[k] = {1'b0, last} + (IDX_W+1)'(k + 1);
            if (pos[k] >= nreq) begin
                pos[k] = pos[k] - nreq;
            end
            if ((IDX_W+1)'(k) < nreq) begin
                rot[k] = req[pos[k][IDX_W-1:0]];
            end
        end
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res.valid = 1'b1;
                res.idx   = pos[k][IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_slice_arbiter_if.sv
// Request/grant bundle between the requesters and the time-sliced counter arbiter.
// The arbiter uses the slave view; the requester side (or a bench) uses master.
interface counter_slice_arbiter_if #(
    parameter int NREQ = 4,
    parameter int N    = 7
) ();

    logic [NREQ-1:0] req;
    logic [N:0]      quantum;
    logic [NREQ-1:0] grant;
    logic            grant_valid;
    logic [N:0]      slice_count;
    logic            slice_expire;

    modport slave (
        input  req,
        input  quantum,
        output grant,
        output grant_valid,
        output slice_count,
        output slice_expire
    );

    modport master (
        output req,
        output quantum,
        input  grant,
        input  grant_valid,
        input  slice_count,
        input  slice_expire
    );

endinterface

// File: rtl/counter_slice_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping through 'last'.
// Pure function of its inputs so any arbiter can drop it in front of its own state.
module counter_slice_arbiter_rr_pick
    import counter_slice_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    localparam logic [IDX_W:0] NREQ_V = (IDX_W+1)'(NREQ);

    logic [MAX_NREQ-1:0] w_req_ext;
    rr_result_t          w_pick;

    assign w_req_ext = MAX_NREQ'(i_req);
    assign w_pick    = rr_next(w_req_ext, i_last, NREQ_V);
    assign o_winner  = w_pick.idx;
    assign o_any     = w_pick.valid;

endmodule

// File: rtl/counter_slice_arbiter.sv
// Round-robin, time-sliced arbiter: one owner at a time, preempted when its latched
// quantum expires; quantum 0 lets the slice counter free-run and never preempt.
module counter_slice_arbiter
    import counter_slice_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 7
) (
    input  logic                  clock,
    input  logic                  clear_n,
    counter_slice_arbiter_if.slave bus
);

    localparam logic [N:0]       CNT_ONE  = (N+1)'(1);
    localparam logic [NREQ-1:0]  OH_ONE   = NREQ'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_last;
    logic [N:0]       r_quantum;
    logic [N:0]       r_count;
    logic [NREQ-1:0]  r_grant;
    logic             r_grant_valid;
    logic             r_expire;

    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic             w_owner_req;
    logic             w_expiry;
    logic [NREQ-1:0]  w_winner_oh;

    counter_slice_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // r_last always names the current owner while in ST_OWN, so the grant mask is enough
    // to tell whether the owner still wants the resource.
    assign w_owner_req = |(bus.req & r_grant);
    assign w_expiry    = (r_quantum != '0) && (r_count == (r_quantum - CNT_ONE));
    assign w_winner_oh = OH_ONE << w_winner;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state       <= ST_IDLE;
            r_last        <= LAST_RST;
            r_quantum     <= '0;
            r_count       <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_expire      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_expire <= 1'b0;
                    if (w_any) begin
                        r_state       <= ST_OWN;
                        r_grant       <= w_winner_oh;
                        r_grant_valid <= 1'b1;
                        r_last        <= w_winner;
                        r_count       <= '0;
                        r_quantum     <= bus.quantum;
                    end
                end
                ST_OWN: begin
                    // Release outranks expiry, so a pulse only fires while the owner still requests.
                    r_expire <= w_owner_req && w_expiry;
                    if (w_owner_req && !w_expiry) begin
                        r_count <= r_count + CNT_ONE;
                    end else if (w_any) begin
                        r_grant       <= w_winner_oh;
                        r_grant_valid <= 1'b1;
                        r_last        <= w_winner;
                        r_count       <= '0;
                        r_quantum     <= bus.quantum;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_count       <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.grant_valid  = r_grant_valid;
    assign bus.slice_count  = r_count;
    assign bus.slice_expire = r_expire;

endmodule

// File: tb/tb_counter_slice_arbiter.sv
// Bench for counter_slice_arbiter: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a behavioural model and drained by an independent monitor.
module tb_counter_slice_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 7;
    localparam int CMAX = 256;

    typedef struct packed {
        logic [3:0] g;
        logic       gv;
        logic [7:0] cnt;
        logic       ex;
    } exp_t;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;

    counter_slice_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();

    counter_slice_arbiter #(.NREQ(NREQ), .N(N)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model: owner index (-1 = none), cycles into slice, latched quantum, pointer.
    int m_owner;
    int m_count;
    int m_q;
    int m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_q     = 0;
        m_last  = NREQ - 1;
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, predict the state after the coming edge, queue it.
    task automatic cycle(input logic [3:0] r, input int q);
        exp_t e;
        int   w;
        logic ex;
        bus.req     = r;
        bus.quantum = 8'(q);
        w  = pick(r);
        ex = 1'b0;
        if (m_owner < 0 || !r[m_owner[1:0]]) begin
            if (w >= 0) begin
                m_owner = w; m_last = w; m_count = 0; m_q = q;
            end else begin
                m_owner = -1; m_count = 0;
            end
        end else if (m_q != 0 && m_count == m_q - 1) begin
            ex = 1'b1;
            m_owner = w; m_last = w; m_count = 0; m_q = q;
        end else begin
            m_count = (m_count + 1) % CMAX;
        end
        e.g   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e.gv  = (m_owner >= 0);
        e.cnt = 8'(m_count);
        e.ex  = ex;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Called one time unit after an edge: pulse reset well clear of both clock edges.
    task automatic reset_pulse();
        #3 clear_n = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_gvalid", 32'(bus.grant_valid), 32'd0);
        check("rst_count", 32'(bus.slice_count), 32'd0);
        check("rst_expire", 32'(bus.slice_expire), 32'd0);
        #1 clear_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(bus.grant), 32'(e.g));
                check("grant_valid", 32'(bus.grant_valid), 32'(e.gv));
                check("slice_count", 32'(bus.slice_count), 32'(e.cnt));
                check("slice_expire", 32'(bus.slice_expire), 32'(e.ex));
                check("onehot", 32'($onehot0(bus.grant)), 32'd1);
                check("gv_is_or", 32'(bus.grant_valid), 32'(|bus.grant));
            end
        end
    end

    initial begin : driver
        logic [3:0] r;
        int         q;
        bus.req     = '0;
        bus.quantum = '0;
        model_reset();
        #10;
        check("init_grant", 32'(bus.grant), 32'd0);
        check("init_gvalid", 32'(bus.grant_valid), 32'd0);
        check("init_count", 32'(bus.slice_count), 32'd0);
        check("init_expire", 32'(bus.slice_expire), 32'd0);
        #10 clear_n = 1'b1;

        // Single requester, unlimited quantum, then release
        for (int i = 0; i < 10; i++) cycle(4'b0001, 0);
        for (int i = 0; i < 3; i++)  cycle(4'b0000, 0);

        // Round-robin with quantum 3 from a fresh pointer
        reset_pulse();
        for (int i = 0; i < 16; i++) cycle(4'b1111, 3);
        for (int i = 0; i < 2; i++)  cycle(4'b0000, 3);

        // Lone requester re-granted every 4 cycles
        for (int i = 0; i < 12; i++) cycle(4'b0100, 4);
        for (int i = 0; i < 2; i++)  cycle(4'b0000, 4);

        // Requester 0 drops on the edge its slice would expire
        for (int i = 0; i < 2; i++)  cycle(4'b0011, 2);
        for (int i = 0; i < 3; i++)  cycle(4'b0010, 2);
        for (int i = 0; i < 2; i++)  cycle(4'b0000, 2);

        // Unlimited wrap; quantum changes mid-slice are not latched
        for (int i = 0; i < 300; i++) cycle(4'b0001, (i < 50) ? 0 : 5);
        for (int i = 0; i < 2; i++)   cycle(4'b0000, 0);

        // Async reset while requester 2 owns, then all request
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle(4'b0100, 0);
        reset_pulse();
        for (int i = 0; i < 6; i++) cycle(4'b1111, 2);

        // Random traffic with sticky requests and occasional resets
        r = 4'b0000;
        q = 1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) q = $urandom_range(0, 5);
            cycle(r, q);
            if ($urandom_range(0, 63) == 0) reset_pulse();
        end
        cycle(4'b0000, 0);

        #5;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
